// File: rtl/stereo_mem_arbiter_pkg.sv
// Shared definitions for the stereo frame-buffer arbiter: FSM encodings, requester IDs and
// default widths.
package stereo_mem_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam int unsigned DEF_ADDR_W          = 24;
  localparam int unsigned DEF_DATA_W          = 32;
  localparam int unsigned DEF_BURST_LEN       = 8;
  localparam int unsigned DEF_MAX_OUTSTANDING = 8;
  localparam int unsigned DEF_WDOG_CYCLES     = 1024;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for outstanding reads. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/stereo_mem_arbiter.sv
// Round-robin burst arbiter sharing one memory port between camera paths A and B, with
// in-order read-data routing. Optional stall watchdog: define ARB_WATCHDOG_EN.
module stereo_mem_arbiter
  import stereo_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned BURST_LEN       = DEF_BURST_LEN,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned WDOG_CYCLES     = DEF_WDOG_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              wr_a,
  input  logic              wr_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              beat_a,
  output logic              beat_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_valid,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_orphan,
  output logic              err_timeout
);

  if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst
    $error("BURST_LEN must be in 1..255");
  end
  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $error("MAX_OUTSTANDING must be a power of 2 and at least 2");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 1");
  end

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_orphan_q;

  logic              own_req, own_wr;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              in_burst, accept, burst_end, wdog_fire;
  logic              fifo_push, fifo_pop, fifo_dout, fifo_full, fifo_empty;

  assign own_req   = (owner_q == ID_B) ? req_b   : req_a;
  assign own_wr    = (owner_q == ID_B) ? wr_b    : wr_a;
  assign own_addr  = (owner_q == ID_B) ? addr_b  : addr_a;
  assign own_wdata = (owner_q == ID_B) ? wdata_b : wdata_a;
  assign in_burst  = (state_q == ST_BURST);

  // A full ID FIFO blocks reads unless a return frees a slot in this same cycle.
  assign fifo_pop  = mem_rvalid & ~fifo_empty;
  assign mem_valid = in_burst & own_req & ~(~own_wr & fifo_full & ~fifo_pop);
  assign accept    = mem_valid & mem_ready;
  assign mem_wr    = in_burst & own_wr;
  assign mem_addr  = in_burst ? own_addr  : '0;
  assign mem_wdata = in_burst ? own_wdata : '0;

  assign gnt_a  = in_burst & (owner_q == ID_A);
  assign gnt_b  = in_burst & (owner_q == ID_B);
  assign beat_a = accept & (owner_q == ID_A);
  assign beat_b = accept & (owner_q == ID_B);

  assign fifo_push = accept & ~own_wr;
  assign rvalid_a  = fifo_pop & (fifo_dout == ID_A);
  assign rvalid_b  = fifo_pop & (fifo_dout == ID_B);
  assign rdata     = fifo_pop ? mem_rdata : '0;

  assign err_orphan = err_orphan_q;
  assign burst_end  = (accept & (cnt_q == LAST_BEAT)) | ~own_req | wdog_fire;

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (owner_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_a | req_b) begin
          state_d = ST_BURST;
          owner_d = (req_a & req_b) ? ptr_q : (req_b ? ID_B : ID_A);
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (burst_end) begin
          state_d = ST_IDLE;
          ptr_d   = ~owner_q;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= ID_A;
      ptr_q        <= ID_A;
      cnt_q        <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (mem_rvalid & fifo_empty) begin
        err_orphan_q <= 1'b1;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_timeout_q, stall;

  assign stall       = in_burst & mem_valid & ~mem_ready;
  assign wdog_fire   = stall & (wdog_q == WDOG_LAST);
  assign err_timeout = err_timeout_q;

  always_comb begin
    wdog_d = wdog_q;
    if (!in_burst || accept || wdog_fire) begin
      wdog_d = '0;
    end else if (stall) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (wdog_fire) begin
        err_timeout_q <= 1'b1;
      end
    end
  end
`else
  assign wdog_fire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stereo_mem_arbiter.sv
// Directed self-checking bench for stereo_mem_arbiter; inputs change 1ns after the rising
// edge and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_stereo_mem_arbiter;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_a, req_b, wr_a, wr_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic              gnt_a, gnt_b, beat_a, beat_b, rvalid_a, rvalid_b;
  logic [DATA_W-1:0] rdata;
  logic              mem_valid, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_orphan, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stereo_mem_arbiter #(
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .BURST_LEN       (8),
    .MAX_OUTSTANDING (8),
    .WDOG_CYCLES     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_a       (req_a),
    .req_b       (req_b),
    .wr_a        (wr_a),
    .wr_b        (wr_b),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .wdata_a     (wdata_a),
    .wdata_b     (wdata_b),
    .gnt_a       (gnt_a),
    .gnt_b       (gnt_b),
    .beat_a      (beat_a),
    .beat_b      (beat_b),
    .rvalid_a    (rvalid_a),
    .rvalid_b    (rvalid_b),
    .rdata       (rdata),
    .mem_valid   (mem_valid),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .err_orphan  (err_orphan),
    .err_timeout (err_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; req_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    n_checks++;
    if ({gnt_a, gnt_b, beat_a, beat_b, rvalid_a, rvalid_b, mem_valid, mem_wr, err_orphan,
         err_timeout} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {gnt_a, gnt_b, beat_a, beat_b, rvalid_a,
               rvalid_b, mem_valid, mem_wr, err_orphan, err_timeout});
    end
    n_checks++;
    if (rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0", rdata, mem_addr,
               mem_wdata);
    end
  endtask

  task automatic test_single_writer();
    apply_reset();
    mem_ready = 1'b1; req_a = 1'b1; wr_a = 1'b1;
    addr_a = 24'h000100; wdata_a = 32'hA000_0000;
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 1'b0 || mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_latency: gnt_a=%b mem_valid=%b required 0 0", gnt_a, mem_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      addr_a  = 24'h000100 + 24'(i);
      wdata_a = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      n_checks++;
      if ({gnt_a, gnt_b, beat_a, beat_b, mem_valid, mem_wr} !== 6'b101011) begin
        n_fail++;
        $display("FAIL t1_beat%0d: got %b required 101011", i,
                 {gnt_a, gnt_b, beat_a, beat_b, mem_valid, mem_wr});
      end
      n_checks++;
      if (mem_addr !== 24'h000100 + 24'(i) || mem_wdata !== 32'hA000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL t1_data%0d: addr=%h wdata=%h required %h %h", i, mem_addr, mem_wdata,
                 24'h000100 + 24'(i), 32'hA000_0000 + 32'(i));
      end
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({gnt_a, beat_a, mem_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL t1_bubble: got %b required 000", {gnt_a, beat_a, mem_valid});
    end
    req_a = 1'b0;
    step();
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_release: gnt_a=%b required 0", gnt_a);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] own;
    logic       o;
    own = 3'b010;
    apply_reset();
    mem_ready = 1'b1; req_a = 1'b1; req_b = 1'b1; wr_a = 1'b1; wr_b = 1'b1;
    addr_a = 24'h000A00; addr_b = 24'h000B00;
    for (int b = 0; b < 3; b++) begin
      o = own[b];
      for (int i = 0; i < 8; i++) begin
        step();
        @(negedge clk);
        n_checks++;
        if ({gnt_a, gnt_b, beat_a, beat_b} !== {~o, o, ~o, o}) begin
          n_fail++;
          $display("FAIL t2_burst%0d_beat%0d: got %b required %b", b, i,
                   {gnt_a, gnt_b, beat_a, beat_b}, {~o, o, ~o, o});
        end
        n_checks++;
        if (mem_addr !== (o ? 24'h000B00 : 24'h000A00)) begin
          n_fail++;
          $display("FAIL t2_addr%0d: got %h required %h", b, mem_addr,
                   o ? 24'h000B00 : 24'h000A00);
        end
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({gnt_a, gnt_b} !== 2'b00) begin
        n_fail++;
        $display("FAIL t2_bubble%0d: got %b required 00", b, {gnt_a, gnt_b});
      end
    end
    idle_inputs();
  endtask

  task automatic test_short_read();
    logic e_gnt, e_beat, e_rv;
    int   n_rv;
    n_rv = 0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      req_b      = (c <= 4);
      wr_b       = 1'b0;
      addr_b     = 24'h000300 + 24'(c);
      mem_ready  = 1'b1;
      mem_rvalid = (c >= 4 && c <= 7);
      mem_rdata  = 32'h0000_D000 + 32'(c) - 32'd3;
      e_gnt  = (c >= 1 && c <= 5);
      e_beat = (c >= 1 && c <= 4);
      e_rv   = (c >= 4 && c <= 7);
      @(negedge clk);
      n_checks++;
      if ({gnt_a, gnt_b, beat_a, beat_b, rvalid_a, rvalid_b} !==
          {1'b0, e_gnt, 1'b0, e_beat, 1'b0, e_rv}) begin
        n_fail++;
        $display("FAIL t3_cycle%0d: got %b required %b", c,
                 {gnt_a, gnt_b, beat_a, beat_b, rvalid_a, rvalid_b},
                 {1'b0, e_gnt, 1'b0, e_beat, 1'b0, e_rv});
      end
      if (e_beat) begin
        n_checks++;
        if (mem_addr !== 24'h000300 + 24'(c) || mem_wr !== 1'b0) begin
          n_fail++;
          $display("FAIL t3_addr%0d: addr=%h wr=%b required %h 0", c, mem_addr, mem_wr,
                   24'h000300 + 24'(c));
        end
      end
      if (e_rv) begin
        n_checks++;
        if (rdata !== 32'h0000_D000 + 32'(c) - 32'd3) begin
          n_fail++;
          $display("FAIL t3_rdata%0d: got %h required %h", c, rdata,
                   32'h0000_D000 + 32'(c) - 32'd3);
        end
      end
      if (rvalid_b === 1'b1) n_rv++;
    end
    n_checks++;
    if (n_rv != 4 || err_orphan !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_count: rvalid_b pulses=%0d err_orphan=%b required 4 0", n_rv,
               err_orphan);
    end
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    logic e_ba, e_bb, e_ra, e_rb;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      if (c > 0) step();
      req_a      = (c <= 4);
      req_b      = (c <= 13);
      wr_a       = 1'b0;
      wr_b       = 1'b0;
      mem_ready  = 1'b1;
      mem_rvalid = (c == 13) || (c >= 15 && c <= 22);
      mem_rdata  = 32'h0000_4000 + 32'(c);
      e_ba = (c >= 1 && c <= 4);
      e_bb = (c >= 7 && c <= 10) || (c == 13);
      e_ra = (c == 13) || (c >= 15 && c <= 17);
      e_rb = (c >= 18 && c <= 22);
      @(negedge clk);
      n_checks++;
      if ({beat_a, beat_b, mem_valid, rvalid_a, rvalid_b} !==
          {e_ba, e_bb, e_ba | e_bb, e_ra, e_rb}) begin
        n_fail++;
        $display("FAIL t4_cycle%0d: got %b required %b", c,
                 {beat_a, beat_b, mem_valid, rvalid_a, rvalid_b},
                 {e_ba, e_bb, e_ba | e_bb, e_ra, e_rb});
      end
      if (e_ra || e_rb) begin
        n_checks++;
        if (rdata !== 32'h0000_4000 + 32'(c)) begin
          n_fail++;
          $display("FAIL t4_rdata%0d: got %h required %h", c, rdata, 32'h0000_4000 + 32'(c));
        end
      end
    end
    n_checks++;
    if (err_orphan !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_orphan: got %b required 0", err_orphan);
    end
    idle_inputs();
  endtask

  task automatic test_orphan_and_reset();
    apply_reset();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0BAD;
    @(negedge clk);
    n_checks++;
    if ({rvalid_a, rvalid_b, err_orphan} !== 3'b000 || rdata !== '0) begin
      n_fail++;
      $display("FAIL t5_orphan_pop: got %b rdata=%h required 000 0",
               {rvalid_a, rvalid_b, err_orphan}, rdata);
    end
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_orphan !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_orphan_set: got %b required 1", err_orphan);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (err_orphan !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_orphan_sticky: got %b required 1", err_orphan);
    end
    step();
    req_a = 1'b1; wr_a = 1'b0; addr_a = 24'h000777; mem_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      @(negedge clk);
      n_checks++;
      if ({gnt_a, beat_a} !== 2'b11) begin
        n_fail++;
        $display("FAIL t5_beat%0d: got %b required 11", c, {gnt_a, beat_a});
      end
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b, beat_a, beat_b, mem_valid, mem_wr, err_orphan, rvalid_a} !== 8'b0 ||
        mem_addr !== '0) begin
      n_fail++;
      $display("FAIL t5_async_reset: got %b addr=%h required 0",
               {gnt_a, gnt_b, beat_a, beat_b, mem_valid, mem_wr, err_orphan, rvalid_a},
               mem_addr);
    end
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    mem_rvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rvalid_a, rvalid_b} !== 2'b00) begin
      n_fail++;
      $display("FAIL t5_discarded: got %b required 00", {rvalid_a, rvalid_b});
    end
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_orphan !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_late_orphan: got %b required 1", err_orphan);
    end
  endtask

`ifdef ARB_WATCHDOG_EN
  task automatic test_watchdog();
    logic e_ga, e_gb, e_to;
    apply_reset();
    req_a = 1'b1; req_b = 1'b1; wr_a = 1'b1; wr_b = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 19; c++) begin
      if (c > 0) step();
      e_ga = (c >= 1 && c <= 16);
      e_gb = (c >= 18);
      e_to = (c >= 17);
      @(negedge clk);
      n_checks++;
      if ({gnt_a, gnt_b, err_timeout} !== {e_ga, e_gb, e_to}) begin
        n_fail++;
        $display("FAIL t6_cycle%0d: gnt_a,gnt_b,err_timeout=%b required %b", c,
                 {gnt_a, gnt_b, err_timeout}, {e_ga, e_gb, e_to});
      end
    end
    idle_inputs();
    step();
  endtask
`else
  task automatic test_watchdog();
    apply_reset();
    req_a = 1'b1; wr_a = 1'b1; mem_ready = 1'b0;
    repeat (20) step();
    @(negedge clk);
    n_checks++;
    if ({gnt_a, mem_valid, err_timeout} !== 3'b110) begin
      n_fail++;
      $display("FAIL t6_no_wdog: got %b required 110", {gnt_a, mem_valid, err_timeout});
    end
    idle_inputs();
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_writer();
    test_round_robin();
    test_short_read();
    test_fifo_full();
    test_orphan_and_reset();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
